// File: rtl/led_blink_pkg.sv
// -----------------------------------------------------------------------------
// led_blink_pkg
// Shared types and helpers for the status-LED blink-code sequencer.
//   blink_state_t : sequencer states (IDLE, PRE_GAP, ON, OFF, LONG, POST_GAP)
//   ticks_w       : width of the per-phase tick counter. Every *_TICKS
//                   parameter of led_blink_coder must fit in this width.
//   div_w()       : width of a prescaler counting 0..DIV-1
// -----------------------------------------------------------------------------
package led_blink_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE_GAP,
        ON,
        OFF,
        LONG,
        POST_GAP
    } blink_state_t;

    // Large enough for any practical tick count (up to 65535 ticks per phase).
    localparam int ticks_w = 16;

    // $clog2(DIV), kept at least 1 so a counter declared with it is never empty.
    function automatic int div_w(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/led_blink_coder_if.sv
// -----------------------------------------------------------------------------
// led_blink_coder_if
// Status-code handshake between the CPU core (master) and the blink-code
// sequencer (slave).
//   code_valid : master offers a code
//   code       : 4-bit blink count, 0..15
//   code_ready : slave can accept a code
//   busy       : a code is being rendered
//   done       : one-cycle pulse when rendering completes
// -----------------------------------------------------------------------------
interface led_blink_coder_if;

    logic       code_valid;
    logic [3:0] code;
    logic       code_ready;
    logic       busy;
    logic       done;

    modport master (
        output code_valid,
        output code,
        input  code_ready,
        input  busy,
        input  done
    );

    modport slave (
        input  code_valid,
        input  code,
        output code_ready,
        output busy,
        output done
    );

endinterface

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running divider counting 0..DIV-1; tick is high for the one cycle in
// which the count sits at DIV-1, so consecutive ticks are DIV clocks apart.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clear : synchronous restart of the count at 0
//   tick  : one-cycle pulse each time the count wraps
// -----------------------------------------------------------------------------
module tick_prescaler
    import led_blink_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int W = div_w(DIV);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = (cnt_q == W'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_blink_coder.sv
// -----------------------------------------------------------------------------
// led_blink_coder
// Renders a 4-bit status code on the user LED as a blink code:
//   gap, then N short blinks (or one long blink for code 0), then gap.
// While idle the LED holds IDLE_LEVEL.
//   CLK   : system clock
//   RST_N : asynchronous active-low reset
//   bus   : code handshake (code_valid/code in, code_ready/busy/done out)
//   led   : drives the LED pin
// All outputs are registered.
// -----------------------------------------------------------------------------
module led_blink_coder
    import led_blink_pkg::*;
#(
    parameter int CLK_HZ     = 16_000_000,
    parameter int TICK_HZ    = 100,
    parameter int ON_TICKS   = 20,
    parameter int OFF_TICKS  = 30,
    parameter int GAP_TICKS  = 100,
    parameter int LONG_TICKS = 60,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic               CLK,
    input  logic               RST_N,
    led_blink_coder_if.slave   bus,
    output logic               led
);

    localparam int DIV = CLK_HZ / TICK_HZ;

    blink_state_t        state_q, state_d;
    logic [3:0]          rem_q, rem_d;
    logic [ticks_w-1:0]  phase_q, phase_d;
    logic                code_ready_q, code_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                led_q, led_d;

    logic                tick;
    logic                accept;
    logic                phase_end;
    logic [ticks_w-1:0]  phase_len;

    // code_ready_q is only ever high in IDLE, so this alone qualifies an accept.
    assign accept = bus.code_valid && code_ready_q;

    // Restarting the prescaler on accept aligns the first tick DIV clocks after
    // the accept edge; on a phase end it has just wrapped anyway.
    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (CLK),
        .rst_n (RST_N),
        .clear (accept || phase_end),
        .tick  (tick)
    );

    always_comb begin
        phase_len = '0;
        case (state_q)
            PRE_GAP,
            POST_GAP: phase_len = ticks_w'(GAP_TICKS);
            ON:       phase_len = ticks_w'(ON_TICKS);
            OFF:      phase_len = ticks_w'(OFF_TICKS);
            LONG:     phase_len = ticks_w'(LONG_TICKS);
            default:  phase_len = '0;
        endcase
    end

    // The final tick of a phase is the one that finds the counter at len-1,
    // so the state changes exactly len*DIV clocks after the phase started.
    assign phase_end = (state_q != IDLE) && tick &&
                       (phase_q == phase_len - ticks_w'(1));

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        phase_d = phase_q;
        done_d  = 1'b0;

        if (tick) begin
            phase_d = phase_q + ticks_w'(1);
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PRE_GAP;
                    rem_d   = bus.code;
                end
            end
            PRE_GAP: begin
                if (phase_end) begin
                    state_d = (rem_q == 4'd0) ? LONG : ON;
                end
            end
            ON: begin
                // rem_q >= 1 here: code 0 never reaches ON.
                if (phase_end) begin
                    rem_d   = rem_q - 4'd1;
                    state_d = (rem_q > 4'd1) ? OFF : POST_GAP;
                end
            end
            OFF: begin
                if (phase_end) begin
                    state_d = ON;
                end
            end
            LONG: begin
                if (phase_end) begin
                    state_d = POST_GAP;
                end
            end
            POST_GAP: begin
                if (phase_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_d != state_q) || (state_q == IDLE)) begin
            phase_d = '0;
        end

        // Outputs are registered from the next state so they change on the
        // same edge as the state itself.
        code_ready_d = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        case (state_d)
            IDLE:     led_d = IDLE_LEVEL;
            ON, LONG: led_d = 1'b1;
            default:  led_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            phase_q      <= '0;
            code_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            led_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            phase_q      <= phase_d;
            code_ready_q <= code_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            led_q        <= led_d;
        end
    end

    assign bus.code_ready = code_ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign led            = led_q;

endmodule

// File: tb/tb_led_blink_coder.sv
// -----------------------------------------------------------------------------
// tb_led_blink_coder
// Drives status codes into led_blink_coder and compares LED and handshake
// outputs every cycle with a timeline built from the blink-code rules
// (gap, N short blinks separated by off times or one long blink, gap).
// -----------------------------------------------------------------------------
module tb_led_blink_coder;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int ON_T    = 2;
    localparam int OFF_T   = 3;
    localparam int GAP_T   = 4;
    localparam int LONG_T  = 6;
    localparam bit IDLE_LVL = 1'b1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic led;

    led_blink_coder_if bus ();

    led_blink_coder #(
        .CLK_HZ     (CLK_HZ),
        .TICK_HZ    (TICK_HZ),
        .ON_TICKS   (ON_T),
        .OFF_TICKS  (OFF_T),
        .GAP_TICKS  (GAP_T),
        .LONG_TICKS (LONG_T),
        .IDLE_LEVEL (IDLE_LVL)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus),
        .led   (led)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected LED level for each clock after the accept edge.
    bit exp_led[$];

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %b, expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_led, input logic e_ready,
                              input logic e_busy, input logic e_done);
        check({tag, ".led"},        led,            e_led);
        check({tag, ".code_ready"}, bus.code_ready, e_ready);
        check({tag, ".busy"},       bus.busy,       e_busy);
        check({tag, ".done"},       bus.done,       e_done);
    endtask

    function automatic void push_level(input bit lvl, input int ticks);
        repeat (ticks * DIV) exp_led.push_back(lvl);
    endfunction

    function automatic void build_model(input int c);
        exp_led.delete();
        push_level(1'b0, GAP_T);
        if (c == 0) begin
            push_level(1'b1, LONG_T);
        end else begin
            for (int i = 1; i <= c; i++) begin
                push_level(1'b1, ON_T);
                if (i < c) push_level(1'b0, OFF_T);
            end
        end
        push_level(1'b0, GAP_T);
    endfunction

    // Reset for n clocks; ends at a negedge with the block idle and ready.
    task automatic reset_pulse(input int n, input bit check_now);
        bus.code_valid = 1'b0;
        rst_n = 1'b0;
        if (check_now) begin
            #1;
            check_outs("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        repeat (n) begin
            @(negedge clk);
            check_outs("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        #1;
        check_outs("rst_release", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_outs("rst_first_clk", IDLE_LVL, 1'b1, 1'b0, 1'b0);
    endtask

    // Called at a negedge with code_valid=1 and code=c already driven and
    // code_ready=1, so the next posedge is the accept edge.
    task automatic render(input logic [3:0] c, input bit chain, input logic [3:0] nxt,
                          input int abort_at);
        int len;
        int t0;
        t0 = cyc + 1;
        build_model(int'(c));
        len = exp_led.size();
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                reset_pulse(3, 1'b1);
                $display("code %2d accepted at cycle %0d, reset at +%0d, aborted", c, t0, k);
                return;
            end
            check_outs("render", exp_led[k], 1'b0, 1'b1, 1'b0);
            // Anything on the bus during rendering must be ignored.
            bus.code       = 4'($urandom);
            bus.code_valid = chain ? 1'b1 : 1'($urandom_range(0, 1));
        end
        bus.code_valid = chain;
        bus.code       = chain ? nxt : 4'($urandom);
        @(negedge clk);
        check_outs("done", IDLE_LVL, 1'b1, 1'b0, 1'b1);
        $display("code %2d accepted at cycle %0d, done at +%0d (expected +%0d)%s",
                 c, t0, cyc - t0, len, chain ? ", next held valid" : "");
        if (!chain) begin
            @(negedge clk);
            check_outs("after_done", IDLE_LVL, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic start_code(input logic [3:0] c, input int idle, input bit chain,
                              input logic [3:0] nxt, input int abort_at);
        repeat (idle) begin
            @(negedge clk);
            check_outs("idle", IDLE_LVL, 1'b1, 1'b0, 1'b0);
            bus.code = 4'($urandom);
        end
        bus.code_valid = 1'b1;
        bus.code       = c;
        render(c, chain, nxt, abort_at);
    endtask

    initial begin
        bit         pending;
        logic [3:0] pcode;
        logic [3:0] c;
        logic [3:0] n;
        bit         ch;

        bus.code_valid = 1'b0;
        bus.code       = 4'd0;

        reset_pulse(5, 1'b0);

        start_code(4'd3, 2, 1'b0, 4'd0, -1);
        start_code(4'd0, 1, 1'b0, 4'd0, -1);
        start_code(4'd1, 0, 1'b1, 4'd2, -1);
        render(4'd2, 1'b0, 4'd0, -1);
        start_code(4'd15, 3, 1'b0, 4'd0, -1);
        start_code(4'd2, 0, 1'b0, 4'd0, 55);
        start_code(4'd5, 1, 1'b0, 4'd0, -1);

        pending = 1'b0;
        pcode   = 4'd0;
        for (int i = 0; i < 10; i++) begin
            c  = 4'($urandom_range(0, 15));
            n  = 4'($urandom_range(0, 15));
            ch = 1'($urandom_range(0, 1));
            if (i == 9) ch = 1'b0;
            if (pending) begin
                render(pcode, ch, n, -1);
            end else begin
                start_code(c, $urandom_range(0, 4), ch, n, -1);
            end
            pending = ch;
            pcode   = n;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/led_blink_coder.md
# led_blink_coder

Status-LED sequencer for the TinyFPGA BX board. It accepts a 4-bit status code from the COMET II core over a valid/ready handshake and renders it on the user LED as a blink code. Each code is a fixed gap, then N short blinks (or one long blink for code 0), then a fixed gap. The top level instantiates it directly in front of the `LED` pin. When no code is being rendered, the LED holds a steady idle level, continuously on by default, to indicate user-program mode.

## Interface
Parameters:
- `CLK_HZ`, 16_000_000, input clock frequency.
- `TICK_HZ`, 100, timing tick rate. `DIV = CLK_HZ/TICK_HZ` must be an integer ≥ 2.
- `ON_TICKS`, 20, short-blink on time.
- `OFF_TICKS`, 30, off time between blinks.
- `GAP_TICKS`, 100, off time before and after a code.
- `LONG_TICKS`, 60, on time of the single blink for code 0.
- `IDLE_LEVEL`, 1, LED level while idle.

Ports:
- `CLK` in 1: system clock.
- `RST_N` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `code_valid` in 1: code offered.
- `code` in 4: blink count, 0..15.
- `code_ready` out 1: block can accept a code.
- `busy` out 1: a code is being rendered.
- `done` out 1: one-cycle pulse when rendering completes.
- `led` out 1: drives the top-level `LED` pin.

## Operation
- All outputs are registered. Reset values: `led`=0, `code_ready`=0, `busy`=0, `done`=0, state IDLE, counters 0.
- The first clock after `RST_N` rises sets `code_ready`=1 and `led`=`IDLE_LEVEL`.
- Accept condition is `code_valid && code_ready` on a rising edge. On accept:
  - `code` is latched;
  - `code_ready` goes to 0;
  - `busy` goes to 1;
  - the prescaler and phase counter clear;
  - the state goes to PRE_GAP.
- `code` is ignored whenever it is not being accepted. Changes during rendering have no effect.
- States and LED levels:
  - IDLE: `led`=`IDLE_LEVEL`.
  - PRE_GAP: `led`=0 for `GAP_TICKS`. Exits to LONG if the latched code is 0, else to ON.
  - ON: `led`=1 for `ON_TICKS`. Decrements the remaining-blink count. Exits to OFF if blinks remain, else to POST_GAP.
  - OFF: `led`=0 for `OFF_TICKS`, then back to ON.
  - LONG: `led`=1 for `LONG_TICKS`, then POST_GAP.
  - POST_GAP: `led`=0 for `GAP_TICKS`, then IDLE. On this exit, `done`=1 for one cycle, `busy`=0, `code_ready`=1, and `led`=`IDLE_LEVEL`.
- The prescaler counts 0..DIV-1 and emits `tick` when it wraps. Each phase counter counts ticks and clears on every state change.
- A phase of N ticks lasts exactly N·DIV clocks.
- Remaining-blink counter is 4 bits and never underflows, because code 0 takes the LONG path.
- The idle level is only entered after a full POST_GAP. The last blink is never followed by an OFF phase.
- `code_valid` held high during `done`: the new code is accepted on the first cycle `code_ready`=1, i.e. the cycle after `done`.
- `RST_N` asserted mid-code: immediate abort to reset values. No `done` is issued.

## Timing
- Accept to first `led` change is 1 clock, from `IDLE_LEVEL` to 0.
- Code n ≥ 1 rendering length: (2·GAP + n·ON + (n−1)·OFF)·DIV clocks, from the accept edge to the `done` edge.
- Code 0 rendering length: (2·GAP + LONG)·DIV clocks.
- `done` and `code_ready` rise on the same edge that `led` returns to `IDLE_LEVEL`.

## Structure
- Package `led_blink_pkg` holds:
  - state enum `blink_state_t` (IDLE, PRE_GAP, ON, OFF, LONG, POST_GAP);
  - a `ticks_w` width constant sized for the largest tick count;
  - a `div_w` function computing `$clog2(DIV)`.
- One sub-module, `tick_prescaler`: parameter `DIV`, with a synchronous `clear` input and a one-cycle `tick` output.

## Test plan
Bench parameters: CLK_HZ=1000, TICK_HZ=100 (DIV=10), ON=2, OFF=3, GAP=4, LONG=6, IDLE_LEVEL=1.
- **Reset:** hold `RST_N` low for 5 clocks, then release → all outputs 0 during reset; `led`=1 and `code_ready`=1 one clock after release.
- **Code 3:** accept at edge t0 → `led` sequence is 0 for 40, 1 for 20, 0 for 30, 1 for 20, 0 for 30, 1 for 20, 0 for 40; `done` at t0+200; `led`=1 after that.
- **Code 0:** accept → `led` is 0 for 40, 1 for 60, 0 for 40; `done` at t0+140.
- **Back-to-back:** `code_valid` held high with code 1, then code 2 → second accept occurs exactly 1 clock after the first `done`; `code` changes during the first rendering are ignored.
- **Code 15:** accept → exactly 15 on-pulses; `done` at t0+(8+30+42)·10 = t0+800.
- **Reset mid-code:** `RST_N` pulsed low at t0+55 during code 2 → `led`=0 immediately, no `done`; after release, idle behaviour resumes and a new code is accepted normally.
